// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared digit width and active-high 7-segment codes {g,f,e,d,c,b,a}
package bcd_disp_pkg;
  localparam int BCD_W = 4;
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;
endpackage

// File: rtl/bcd_scan_display_dec.sv
// bcd_to_7seg: combinational BCD to active-high segments, dash for 10..15, off when blanked
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  input  logic             blank,
  output logic [6:0]       seg
);
  logic [6:0] raw;
  always_comb begin
    case (bcd)
      4'd0:    raw = SEG_0;
      4'd1:    raw = SEG_1;
      4'd2:    raw = SEG_2;
      4'd3:    raw = SEG_3;
      4'd4:    raw = SEG_4;
      4'd5:    raw = SEG_5;
      4'd6:    raw = SEG_6;
      4'd7:    raw = SEG_7;
      4'd8:    raw = SEG_8;
      4'd9:    raw = SEG_9;
      default: raw = SEG_DASH;
    endcase
  end
  assign seg = blank ? SEG_OFF : raw;
endmodule

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: frame-coherent snapshot of BCD digits scanned onto a multiplexed 7-segment display
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        lzb_en,
  input  logic [NUM_DIGITS*BCD_W-1:0] digits,
  output logic [NUM_DIGITS-1:0]       an,
  output logic [6:0]                  seg,
  output logic                        frame_start
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_INV = {NUM_DIGITS{SEG_ACTIVE_LOW}};
  localparam logic [6:0] SEG_INV = {7{SEG_ACTIVE_LOW}};
  logic [CW-1:0]               cnt;
  logic [IW-1:0]               idx;
  logic [NUM_DIGITS*BCD_W-1:0] snap;
  logic [BCD_W-1:0]            cur;
  logic [NUM_DIGITS-1:0]       sel;
  logic [6:0]                  dec;
  logic                        tick;
  logic                        nz_above;
  logic                        blank;
  assign tick = cnt == CNT_MAX;
  always_comb begin
    cur = '0;
    sel = '0;
    nz_above = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx) begin
        cur = snap[i*BCD_W +: BCD_W];
        sel[i] = 1'b1;
      end
      if (IW'(i) >= idx && snap[i*BCD_W +: BCD_W] != '0) nz_above = 1'b1;
    end
  end
  assign blank = lzb_en && idx != '0 && !nz_above;
  bcd_to_7seg u_dec (
    .bcd   (cur),
    .blank (blank),
    .seg   (dec)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      idx         <= '0;
      snap        <= '0;
      frame_start <= 1'b0;
      an          <= AN_INV;
      seg         <= SEG_OFF ^ SEG_INV;
    end else begin
      cnt         <= tick ? '0 : cnt + 1'b1;
      idx         <= tick ? (idx == IDX_MAX ? '0 : idx + 1'b1) : idx;
      snap        <= (tick && idx == IDX_MAX) ? digits : snap;
      frame_start <= tick && idx == IDX_MAX;
      an          <= (en ? sel : '0) ^ AN_INV;
      seg         <= (en ? dec : SEG_OFF) ^ SEG_INV;
    end
  end
endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: random and directed stimulus against an edge-count reference model
module tb_bcd_scan_display;
  localparam int N = 4;
  localparam int R = 4;
  localparam logic [6:0] LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b1;
  logic lzb_en = 1'b0;
  logic [15:0] digits = 16'h1234;
  logic [3:0] an;
  logic [6:0] seg;
  logic frame_start;
  int n_vec = 0;
  int n_err = 0;
  int k = 0;
  logic [15:0] msnap = '0;
  logic mfs = 1'b0;
  always #5 clk = ~clk;
  bcd_scan_display #(.NUM_DIGITS(N), .REFRESH_DIV(R), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .lzb_en      (lzb_en),
    .digits      (digits),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic cycle();
    logic [3:0] ea;
    logic [6:0] es;
    logic [3:0] d;
    logic bl;
    int ix;
    @(posedge clk);
    #1;
    if (!rst) begin
      k = 0;
      msnap = '0;
      mfs = 1'b0;
      ea = 4'hF;
      es = 7'h7F;
    end else begin
      ix = (k / R) % N;
      d = msnap[ix*4 +: 4];
      bl = lzb_en && ix != 0 && (msnap >> (4 * ix)) == 16'h0;
      ea = en ? ~(4'b0001 << ix) : 4'hF;
      es = (en && !bl) ? ~LUT[d] : 7'h7F;
      k++;
      mfs = (k % R == 0) && ((k / R) % N == 0);
      if (mfs) msnap = digits;
    end
    chk("an", 32'(an), 32'(ea));
    chk("seg", 32'(seg), 32'(es));
    chk("frame_start", 32'(frame_start), 32'(mfs));
  endtask
  task automatic run(input int n);
    repeat (n) cycle();
  endtask
  task automatic wait_fs();
    for (int i = 0; i < 64; i++) begin
      cycle();
      if (mfs) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_fs: no frame boundary within 64 cycles");
  endtask
  initial begin
    run(3);
    rst = 1'b1;
    cycle();
    chk("rel_an", 32'(an), 32'h0E);
    chk("rel_seg", 32'(seg), 32'h40);
    wait_fs();
    run(1); chk("scan_an0", 32'(an), 32'h0E); chk("scan_seg0", 32'(seg), 32'h19);
    run(4); chk("scan_an1", 32'(an), 32'h0D); chk("scan_seg1", 32'(seg), 32'h30);
    run(4); chk("scan_an2", 32'(an), 32'h0B); chk("scan_seg2", 32'(seg), 32'h24);
    run(4); chk("scan_an3", 32'(an), 32'h07); chk("scan_seg3", 32'(seg), 32'h79);
    digits = 16'h0050;
    lzb_en = 1'b1;
    wait_fs();
    run(1); chk("lzb_d0", 32'(seg), 32'h40);
    run(4); chk("lzb_d1", 32'(seg), 32'h12);
    run(4); chk("lzb_d2", 32'(seg), 32'h7F);
    run(4); chk("lzb_d3", 32'(seg), 32'h7F);
    digits = 16'h0000;
    wait_fs();
    run(1); chk("zero_d0", 32'(seg), 32'h40);
    run(4); chk("zero_d1", 32'(seg), 32'h7F);
    run(8);
    digits = 16'h000B;
    lzb_en = 1'b0;
    wait_fs();
    run(1); chk("dash_d0", 32'(seg), 32'h3F);
    digits = 16'h1111;
    wait_fs();
    run(5);
    digits = 16'h2222;
    run(1); chk("coh_old", 32'(seg), 32'h79);
    wait_fs();
    run(1); chk("coh_new", 32'(seg), 32'h24);
    run(2);
    en = 1'b0;
    run(1); chk("en_an", 32'(an), 32'h0F); chk("en_seg", 32'(seg), 32'h7F);
    run(5);
    en = 1'b1;
    run(8);
    wait_fs();
    run(9);
    rst = 1'b0;
    cycle(); chk("mrst_an", 32'(an), 32'h0F); chk("mrst_seg", 32'(seg), 32'h7F);
    rst = 1'b1;
    cycle(); chk("mrst_rel_an", 32'(an), 32'h0E);
    run(20);
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 7) == 0)
        for (int j = 0; j < 4; j++) digits[j*4 +: 4] = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 31) == 0) lzb_en = ~lzb_en;
      if ($urandom_range(0, 15) == 0) en = ~en;
      rst = ($urandom_range(0, 199) != 0);
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Downstream consumer of the decade (mod-10) counters; drives a multiplexed common-anode 7-segment display with NUM_DIGITS digits.
- Takes packed 4-bit BCD digits from a chain of decade counters and captures a coherent snapshot once per scan frame, so ripple-counter glitches are never displayed.
- Scans one digit per refresh tick and decodes BCD to segments.
- Optionally blanks leading zeros.

Parameters:
- NUM_DIGITS, 4, number of BCD digits/anodes (legal 2..8)
- REFRESH_DIV, 50000, clk cycles per digit slot (legal >= 2); prescaler width clog2(REFRESH_DIV)
- SEG_ACTIVE_LOW, 1, 1 = seg and an outputs active-low; 0 = active-high

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  reset, synchronous, active-low
- en  input  1  1 = display on; 0 = all anodes inactive (scan keeps running)
- lzb_en  input  1  1 = leading-zero blanking enabled
- digits  input  NUM_DIGITS*4  packed BCD; digit i = digits[4i+3:4i]; digit 0 = least significant
- an  output  NUM_DIGITS  one-hot digit select (polarity per SEG_ACTIVE_LOW)
- seg  output  7  segments {g,f,e,d,c,b,a} (polarity per SEG_ACTIVE_LOW)
- frame_start  output  1  one-cycle pulse, high in the first cycle the new snapshot is held

Behaviour:
- All registers update on rising clk. rst=0 at an edge forces: prescaler cnt=0, idx=0, snap=0, frame_start=0, an=all inactive, seg=all off. With SEG_ACTIVE_LOW=1 this is an='1 and seg=7'h7F.
- Reset applied mid-operation has the same effect at the next edge; nothing is preserved.
- Prescaler: cnt counts 0..REFRESH_DIV-1 and wraps to 0. tick = (cnt==REFRESH_DIV-1). The first tick after reset release occurs REFRESH_DIV cycles later.
- Digit index: on tick, idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1. Scan order is 0,1,...,NUM_DIGITS-1, then repeats.
- Snapshot: on tick with idx==NUM_DIGITS-1, snap <= digits and frame_start <= 1. Otherwise frame_start <= 0.
- Digits changes at any other time have no effect until the next frame boundary.
- Output stage, registered every cycle from the current idx and snap, so outputs lag idx/snap by exactly 1 clk:
  - an <= en ? onehot(idx) : none, inverted when SEG_ACTIVE_LOW.
  - seg <= decode(snap digit idx, blank), inverted when SEG_ACTIVE_LOW.
- Decode, active-high: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. Codes 10..15 decode to dash (40). blank decodes to 00.
- Leading-zero blanking: blank = lzb_en and idx != 0 and snap digits idx..NUM_DIGITS-1 all zero. Digit 0 is never blanked, so value 0 shows "0".
- en=0 forces seg off as well as an inactive; prescaler, idx and snapshot keep running.
- Simultaneous tick and reset: reset wins.

Decomposition:
- Package bcd_disp_pkg holds:
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF (active-high 7-bit)
  - the digit-width constant BCD_W=4
- One sub-module, bcd_to_7seg: purely combinational, 4-bit BCD plus blank -> 7-bit active-high segments, instantiated once on the muxed digit.
- Polarity inversion, prescaler, scan and snapshot logic stay in the top.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, SEG_ACTIVE_LOW=1, en=1 unless noted.
- Reset: hold rst=0 for 3 cycles with digits=16'h1234 -> an=4'hF, seg=7'h7F every cycle. After release with lzb_en=0 -> first frame shows snapshot 0000, e.g. cycle 1 an=4'b1110 seg=7'h40.
- Scan/snapshot: digits=16'h1234 held. Second frame -> frame_start pulses once, then an steps 1110,1101,1011,0111 every 4 cycles. seg=7'h19 (4), 7'h30 (3), 7'h24 (2), 7'h79 (1).
- Blanking: digits=16'h0050, lzb_en=1 -> digit0 seg=7'h40, digit1 seg=7'h12, digits2-3 seg=7'h7F. digits=16'h0000 -> only digit0 lit with 7'h40.
- Invalid code: digits=16'h000B, lzb_en=0 -> digit0 seg=7'h3F (dash).
- Coherence and enable: change digits from 16'h1111 to 16'h2222 while idx=1 -> 1s are shown until the next frame_start, then 2s. Drive en=0 for 6 cycles -> an=4'hF and seg=7'h7F with a 1-cycle lag; the scan phase is unchanged on return.
- Reset mid-frame: assert rst=0 while idx=2 -> at the next edge an=4'hF, seg=7'h7F. After release, digit 0 is shown first and the first tick comes 4 cycles later.
